// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the BCD word scanner.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_MAX     = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_word_scanner_if.sv
// Request/result bundle between a digit source and bcd_word_scanner.
// master = requester (drives start/word), slave = scanner.
interface bcd_word_scanner_if #(parameter int unsigned DIGITS = 4);
  import bcd_pkg::*;

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  logic                          start;
  logic [BCD_DIGIT_W*DIGITS-1:0] word;
  logic                          busy;
  logic                          done;
  logic                          all_valid;
  logic [CNT_W-1:0]              bad_count;
  logic [IDX_W-1:0]              first_bad;
  logic                          first_bad_vld;

  modport master (
    output start, word,
    input  busy, done, all_valid, bad_count, first_bad, first_bad_vld
  );

  modport slave (
    input  start, word,
    output busy, done, all_valid, bad_count, first_bad, first_bad_vld
  );

endinterface

// File: rtl/bcd_digit_valid.sv
// Single BCD digit check: y = 1 iff x <= 9.
module bcd_digit_valid
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] x,
  output logic                   y
);

  // Combinational range compare against the largest decimal digit.
  always_comb begin
    y = (x <= BCD_DIGIT_W'(BCD_MAX));
  end

endmodule

// File: rtl/bcd_word_scanner.sv
// Scans a packed BCD word one digit per cycle (LSD first) through a single
// shared digit checker and reports validity, bad-digit count and the index
// of the lowest bad digit. All outputs are registered.
// Optional: define BCD_SCAN_EARLY_ABORT_EN to stop at the first bad digit.
module bcd_word_scanner
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_word_scanner_if.slave  bus
);

  localparam int unsigned WORD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   fb_q, fb_d;
  logic               fbv_q, fbv_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               all_valid_q, all_valid_d;
  logic [CNT_W-1:0]   bad_count_q, bad_count_d;
  logic [IDX_W-1:0]   first_bad_q, first_bad_d;
  logic               first_bad_vld_q, first_bad_vld_d;

  logic               digit_ok;
  logic               last_digit;

  bcd_digit_valid u_digit_valid (
    .x (shreg_q[BCD_DIGIT_W-1:0]),
    .y (digit_ok)
  );

  // Next-state, datapath and result-register logic for the scan FSM.
  always_comb begin
    state_d         = state_q;
    shreg_d         = shreg_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    fb_d            = fb_q;
    fbv_d           = fbv_q;
    done_d          = 1'b0;
    all_valid_d     = all_valid_q;
    bad_count_d     = bad_count_q;
    first_bad_d     = first_bad_q;
    first_bad_vld_d = first_bad_vld_q;
    last_digit      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.word;
          idx_d   = '0;
          cnt_d   = '0;
          fb_d    = '0;
          fbv_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        shreg_d = shreg_q >> BCD_DIGIT_W;
        if (!digit_ok) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!fbv_q) begin
            fb_d  = idx_q;
            fbv_d = 1'b1;
          end
        end
`ifdef BCD_SCAN_EARLY_ABORT_EN
        last_digit = (idx_q == IDX_LAST) || !digit_ok;
`else
        last_digit = (idx_q == IDX_LAST);
`endif
        // Results are loaded on the edge entering DONE (from the _d values
        // so the final digit is included) so they are valid with done.
        if (last_digit) begin
          state_d         = ST_DONE;
          done_d          = 1'b1;
          all_valid_d     = (cnt_d == '0);
          bad_count_d     = cnt_d;
          first_bad_d     = fb_d;
          first_bad_vld_d = fbv_d;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      shreg_q         <= '0;
      idx_q           <= '0;
      cnt_q           <= '0;
      fb_q            <= '0;
      fbv_q           <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      all_valid_q     <= 1'b0;
      bad_count_q     <= '0;
      first_bad_q     <= '0;
      first_bad_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      fb_q            <= fb_d;
      fbv_q           <= fbv_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      all_valid_q     <= all_valid_d;
      bad_count_q     <= bad_count_d;
      first_bad_q     <= first_bad_d;
      first_bad_vld_q <= first_bad_vld_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.all_valid     = all_valid_q;
  assign bus.bad_count     = bad_count_q;
  assign bus.first_bad     = first_bad_q;
  assign bus.first_bad_vld = first_bad_vld_q;

endmodule

// File: tb/tb_bcd_word_scanner.sv
// Directed self-checking bench for bcd_word_scanner with DIGITS = 4.
// Expected values follow BCD_SCAN_EARLY_ABORT_EN when it is defined.
module tb_bcd_word_scanner;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

`ifdef BCD_SCAN_EARLY_ABORT_EN
  localparam bit EA = 1'b1;
`else
  localparam bit EA = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd_word_scanner_if #(.DIGITS(4)) bus ();

  bcd_word_scanner #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Present a start pulse sampled at the next edge (cycle 1 begins after it).
  task automatic launch(input logic [15:0] w);
    bus.word  = w;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Watch a bounded number of cycles, recording busy span and done pulses.
  task automatic observe(input int max_cyc, output int done_cyc,
                         output int busy_first, output int busy_last,
                         output int done_cnt);
    done_cyc = -1; busy_first = -1; busy_last = -1; done_cnt = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.word = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    total++; if (bus.all_valid !== 1'b0) begin bad++; $display("FAIL reset_all_valid got=%0b exp=0", bus.all_valid); end
    total++; if (bus.bad_count !== 3'd0) begin bad++; $display("FAIL reset_bad_count got=%0d exp=0", bus.bad_count); end
    total++; if (bus.first_bad !== 2'd0) begin bad++; $display("FAIL reset_first_bad got=%0d exp=0", bus.first_bad); end
    total++; if (bus.first_bad_vld !== 1'b0) begin bad++; $display("FAIL reset_first_bad_vld got=%0b exp=0", bus.first_bad_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_valid_word;
    int dc, bf, bl, dn;
    launch(16'h1234);
    observe(8, dc, bf, bl, dn);
    total++; if (dc != 5) begin bad++; $display("FAIL valid_done_cycle got=%0d exp=5", dc); end
    total++; if (dn != 1) begin bad++; $display("FAIL valid_done_count got=%0d exp=1", dn); end
    total++; if (bf != 1 || bl != 5) begin bad++; $display("FAIL valid_busy_span got=%0d..%0d exp=1..5", bf, bl); end
    total++; if (bus.all_valid !== 1'b1) begin bad++; $display("FAIL valid_all_valid got=%0b exp=1", bus.all_valid); end
    total++; if (bus.bad_count !== 3'd0) begin bad++; $display("FAIL valid_bad_count got=%0d exp=0", bus.bad_count); end
    total++; if (bus.first_bad_vld !== 1'b0) begin bad++; $display("FAIL valid_first_bad_vld got=%0b exp=0", bus.first_bad_vld); end
  endtask

  task automatic test_two_bad;
    int dc, bf, bl, dn;
    int exp_dc  = EA ? 3 : 5;
    int exp_cnt = EA ? 1 : 2;
    launch(16'hA0B9);
    observe(8, dc, bf, bl, dn);
    total++; if (dc != exp_dc) begin bad++; $display("FAIL two_bad_done_cycle got=%0d exp=%0d", dc, exp_dc); end
    total++; if (bl != exp_dc) begin bad++; $display("FAIL two_bad_busy_last got=%0d exp=%0d", bl, exp_dc); end
    total++; if (bus.all_valid !== 1'b0) begin bad++; $display("FAIL two_bad_all_valid got=%0b exp=0", bus.all_valid); end
    total++; if (bus.bad_count !== 3'(exp_cnt)) begin bad++; $display("FAIL two_bad_bad_count got=%0d exp=%0d", bus.bad_count, exp_cnt); end
    total++; if (bus.first_bad !== 2'd1) begin bad++; $display("FAIL two_bad_first_bad got=%0d exp=1", bus.first_bad); end
    total++; if (bus.first_bad_vld !== 1'b1) begin bad++; $display("FAIL two_bad_first_bad_vld got=%0b exp=1", bus.first_bad_vld); end
  endtask

  task automatic test_all_bad;
    int dc, bf, bl, dn;
    int exp_dc  = EA ? 2 : 5;
    int exp_cnt = EA ? 1 : 4;
    launch(16'hFFFF);
    observe(8, dc, bf, bl, dn);
    total++; if (dc != exp_dc) begin bad++; $display("FAIL all_bad_done_cycle got=%0d exp=%0d", dc, exp_dc); end
    total++; if (bus.bad_count !== 3'(exp_cnt)) begin bad++; $display("FAIL all_bad_bad_count got=%0d exp=%0d", bus.bad_count, exp_cnt); end
    total++; if (bus.first_bad !== 2'd0 || bus.first_bad_vld !== 1'b1) begin bad++; $display("FAIL all_bad_first_bad got=%0d/%0b exp=0/1", bus.first_bad, bus.first_bad_vld); end
    launch(16'h9999);
    observe(8, dc, bf, bl, dn);
    total++; if (dc != 5) begin bad++; $display("FAIL nines_done_cycle got=%0d exp=5", dc); end
    total++; if (bus.all_valid !== 1'b1) begin bad++; $display("FAIL nines_all_valid got=%0b exp=1", bus.all_valid); end
    total++; if (bus.bad_count !== 3'd0 || bus.first_bad_vld !== 1'b0) begin bad++; $display("FAIL nines_counts got=%0d/%0b exp=0/0", bus.bad_count, bus.first_bad_vld); end
  endtask

  task automatic test_start_while_busy;
    int dc = -1, dn = 0;
    int dc2, bf2, bl2, dn2;
    int exp_dc2  = EA ? 2 : 5;
    int exp_cnt2 = EA ? 1 : 4;
    launch(16'h1234);
    for (int c = 1; c <= 6; c++) begin
      bus.word  = 16'hFFFF;
      bus.start = (c == 2 || c == 5 || c == 6);
      @(negedge clk);
      if (bus.done === 1'b1) begin dn++; if (dc < 0) dc = c; end
      if (c == 5) begin
        total++; if (bus.all_valid !== 1'b1 || bus.bad_count !== 3'd0) begin bad++; $display("FAIL busy_start_result got=%0b/%0d exp=1/0", bus.all_valid, bus.bad_count); end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    total++; if (dc != 5 || dn != 1) begin bad++; $display("FAIL busy_start_done got=cyc%0d/n%0d exp=cyc5/n1", dc, dn); end
    observe(8, dc2, bf2, bl2, dn2);
    total++; if (bf2 != 1) begin bad++; $display("FAIL busy_start_accept got=%0d exp=1", bf2); end
    total++; if (dc2 != exp_dc2) begin bad++; $display("FAIL busy_start_next_done got=%0d exp=%0d", dc2, exp_dc2); end
    total++; if (bus.bad_count !== 3'(exp_cnt2)) begin bad++; $display("FAIL busy_start_next_count got=%0d exp=%0d", bus.bad_count, exp_cnt2); end
  endtask

  task automatic test_reset_mid_scan;
    int dc, bf, bl, dn;
    launch(16'hA0B9);
    observe(8, dc, bf, bl, dn);
    launch(16'hA0B9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    observe(8, dc, bf, bl, dn);
    total++; if (dn != 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d exp=0", dn); end
    total++; if (bf != -1) begin bad++; $display("FAIL rst_mid_busy got=%0d exp=-1", bf); end
    total++; if (bus.all_valid !== 1'b0 || bus.bad_count !== 3'd0) begin bad++; $display("FAIL rst_mid_result got=%0b/%0d exp=0/0", bus.all_valid, bus.bad_count); end
    total++; if (bus.first_bad !== 2'd0 || bus.first_bad_vld !== 1'b0) begin bad++; $display("FAIL rst_mid_first_bad got=%0d/%0b exp=0/0", bus.first_bad, bus.first_bad_vld); end
  endtask

  task automatic test_results_hold;
    int dc, bf, bl, dn;
    int exp_prev = EA ? 1 : 2;
    launch(16'hA0B9);
    observe(8, dc, bf, bl, dn);
    launch(16'h1234);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c < 5) begin
        total++; if (bus.bad_count !== 3'(exp_prev) || bus.done !== 1'b0) begin bad++; $display("FAIL hold_c%0d got=%0d/%0b exp=%0d/0", c, bus.bad_count, bus.done, exp_prev); end
      end else begin
        total++; if (bus.bad_count !== 3'd0 || bus.done !== 1'b1 || bus.all_valid !== 1'b1) begin bad++; $display("FAIL hold_final got=%0d/%0b/%0b exp=0/1/1", bus.bad_count, bus.done, bus.all_valid); end
      end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_valid_word();
    test_two_bad();
    test_all_bad();
    test_start_while_busy();
    test_reset_mid_scan();
    test_results_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_word_scanner.md
# bcd_word_scanner

Sequencing controller for the 4-bit BCD-digit validity function (valid iff digit ≤ 9). It accepts a packed multi-digit word on a start pulse and feeds one nibble per cycle through a single shared checker instance, least-significant digit first. It reports an aggregate valid flag, the count of invalid digits, and the index of the first invalid digit. It sits between a digit source (switch/keypad capture) and display or error logic.

## Interface
- `DIGITS`, default 4: number of packed BCD digits; legal range 2..8.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `start` input 1: request a scan; sampled only in IDLE.
- `word` input `4*DIGITS`: packed digits; digit i = `word[4i+3:4i]`; captured when start is accepted.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: single-cycle pulse when results become valid.
- `all_valid` output 1: 1 iff no invalid digit was found.
- `bad_count` output `$clog2(DIGITS+1)`: number of invalid digits found.
- `first_bad` output `$clog2(DIGITS)`: index of the lowest invalid digit.
- `first_bad_vld` output 1: first_bad is meaningful.

## Operation
- **States:** IDLE, SCAN, DONE.
  - IDLE: if start = 1, capture word into a shift register, clear the internal accumulators and idx, then go to SCAN. Otherwise stay in IDLE.
  - SCAN: each cycle, check the digit at position idx.
    - If the digit is invalid, increment the accumulator count. If no bad digit has been recorded yet, record idx as first_bad.
    - When idx = DIGITS-1, go to DONE. Otherwise increment idx.
  - DONE: load the result outputs from the accumulators, assert done, then go to IDLE.
- start is ignored while busy, including during the done cycle; it is not queued.
- The result outputs hold their values from the done cycle until the next DONE. A new scan does not disturb them until it completes.
- all_valid = (bad_count == 0).
- bad_count cannot overflow because its width covers 0..DIGITS.
- **Reset:** a reset at any point, including mid-SCAN, forces IDLE on the next edge and clears all registers. No done pulse follows.
- **Reset values:**
  - busy = 0, done = 0
  - all_valid = 0, bad_count = 0
  - first_bad = 0, first_bad_vld = 0

## Timing
- start sampled high at edge k.
- SCAN occupies cycles k+1 .. k+DIGITS, one digit per cycle.
- done is high for exactly cycle k+DIGITS+1, and the results are valid in that same cycle.
- busy is high for cycles k+1 .. k+DIGITS+1.
- The earliest next accepted start is at edge k+DIGITS+2, giving a throughput of one word per DIGITS+2 cycles.
- All outputs are registered; there is no combinational path from start or word to any output.

## Configuration
- **`BCD_SCAN_EARLY_ABORT_EN` defined:** SCAN goes to DONE on the first invalid digit.
  - Results: bad_count = 1, first_bad = that index, first_bad_vld = 1.
  - Latency when the first bad digit is at index j: done in cycle k+j+2.
  - Fully valid words keep the normal latency.
- **Not defined:** every digit is always scanned and bad_count is the full count.

## Structure
- Shared package `bcd_pkg` holds:
  - `BCD_DIGIT_W = 4`
  - `BCD_MAX = 9`
  - state encodings `ST_IDLE = 2'd0`, `ST_SCAN = 2'd1`, `ST_DONE = 2'd2`
- One sub-module, `bcd_digit_valid`: purely combinational, 4-bit input x, output y = (x ≤ 9). It has one instance, fed from the low nibble of the shift register.
- The top level contains the FSM, the idx counter, the shift register and the accumulators.

## Test plan
All scenarios use DIGITS = 4.
- **Valid word:** `word = 16'h1234`, start at edge 0.
  - busy is high for cycles 1–5; done is high in cycle 5.
  - all_valid = 1, bad_count = 0, first_bad_vld = 0.
- **Two bad digits:** `word = 16'hA0B9`, full scan.
  - done in cycle 5, all_valid = 0, bad_count = 2, first_bad = 1, first_bad_vld = 1.
  - Same word with `BCD_SCAN_EARLY_ABORT_EN` defined: done in cycle 3, bad_count = 1, first_bad = 1.
- **All bad:** `word = 16'hFFFF`.
  - bad_count = 4, first_bad = 0.
  - Boundary input `16'h9999`: all_valid = 1.
- **Start while busy:** start pulses at cycles 2 and 5 during a scan of `16'h1234` with word = `16'hFFFF`.
  - Both pulses are ignored; results reflect `1234`.
  - A start at cycle 6 is accepted.
- **Reset mid-scan:** rst_n = 0 at cycle 3 of a scan of `16'hA0B9`.
  - From the next edge: busy = 0, all outputs at their reset values, and no done pulse follows.
- **Results hold:** after the `16'hA0B9` result, start a scan of `16'h1234`.
  - bad_count stays 2 until the second done, then becomes 0.
